// File: rtl/seg_scan_driver_if.sv
// Display bus between the watch top and the segment scan driver.
// master drives the display word, mode and alarm; slave drives the panel.
interface seg_scan_driver_if;
   logic [47:0] disp_i;
   logic [7:0]  mode_i;
   logic        alm_i;
   logic [7:0]  seg_o;
   logic [5:0]  dig_o;
   logic [7:0]  led_o;
   logic        buzz_o;

   modport master (
      output disp_i, mode_i, alm_i,
      input  seg_o, dig_o, led_o, buzz_o
   );

   modport slave (
      input  disp_i, mode_i, alm_i,
      output seg_o, dig_o, led_o, buzz_o
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver with blank gap, mode LEDs, buzzer.
// Optional SEG_SCAN_ALARM_FLASH_EN: display flashes in phase with the buzzer.
module seg_scan_driver #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 4,
   parameter int BUZZ_DIV  = 5000
) (
   input logic              clk,
   input logic              rst,
   seg_scan_driver_if.slave bus
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BUZZ_DIV);

   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    idx, idx_nx;
   logic [47:0]   snap, snap_nx;
   logic          bph, bph_nx;
   logic [BW-1:0] bcnt, bcnt_nx;
   logic [7:0]    seg_nx;
   logic [5:0]    dig_nx;
   logic          buzz_nx;
   logic          cnt_wrap;
   logic          bcnt_wrap;
   logic          flash;
   logic          blank;

`ifdef SEG_SCAN_ALARM_FLASH_EN
   assign flash = bus.alm_i & ~bph;
`else
   assign flash = 1'b0;
`endif

   assign cnt_wrap  = (cnt == CW'(SCAN_DIV - 1));
   assign bcnt_wrap = (bcnt == BW'(BUZZ_DIV - 1));
   assign blank     = (cnt < CW'(BLANK_CYC)) | flash;

   always_comb begin
      cnt_nx  = cnt_wrap ? '0 : cnt + 1'b1;
      idx_nx  = idx;
      snap_nx = snap;
      bph_nx  = 1'b0;
      bcnt_nx = '0;
      buzz_nx = 1'b0;
      seg_nx  = 8'hFF;
      dig_nx  = 6'h3F;

      if (cnt_wrap)
         idx_nx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

      // Latch the whole word once per frame so digits never tear.
      if (cnt == '0 && idx == 3'd0)
         snap_nx = bus.disp_i;

      if (!blank) begin
         dig_nx = ~(6'b1 << idx);
         seg_nx = ~snap[{idx, 3'b000} +: 8];
      end

      if (bus.alm_i) begin
         bcnt_nx = bcnt_wrap ? '0 : bcnt + 1'b1;
         bph_nx  = bcnt_wrap ? ~bph : bph;
         buzz_nx = bph;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         snap       <= '0;
         bph        <= 1'b0;
         bcnt       <= '0;
         bus.seg_o  <= 8'hFF;
         bus.dig_o  <= 6'h3F;
         bus.led_o  <= 8'h00;
         bus.buzz_o <= 1'b0;
      end else begin
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         snap       <= snap_nx;
         bph        <= bph_nx;
         bcnt       <= bcnt_nx;
         bus.seg_o  <= seg_nx;
         bus.dig_o  <= dig_nx;
         bus.led_o  <= bus.mode_i;
         bus.buzz_o <= buzz_nx;
      end
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display-side consumer of the watch top's outputs: 48-bit segment word, 8-bit mode LEDs, alarm flag.
- Time-multiplexes 6 seven-segment digits with active-low segment and digit drives.
- Inserts an anti-ghosting blank gap at the start of every digit slot.
- Drives the mode LEDs and a square-wave buzzer while the alarm is asserted.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; must be >= 4.
- BLANK_CYC, 4: cycles at the start of each slot with all digits off; 1 <= BLANK_CYC < SCAN_DIV.
- BUZZ_DIV, 5000: clk cycles per buzzer half-period; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- disp_i  input  48  segment word. Byte k = disp_i[8k+7:8k] = {dp,g,f,e,d,c,b,a} for digit k. 1 = segment lit. Digit 0 is rightmost.
- mode_i  input  8  one-hot mode indicator.
- alm_i  input  1  alarm request, level.
- seg_o  output  8  segment drive, active-low, registered.
- dig_o  output  6  digit enable, active-low one-hot, registered.
- led_o  output  8  mode LEDs, registered copy of mode_i.
- buzz_o  output  1  buzzer square wave, registered.

Behaviour:
- Reset: synchronous, active-high, decided. All state clears on the posedge where rst=1.
  - cnt=0, idx=0, snap=0, bph=0, bcnt=0.
  - Outputs: seg_o=8'hFF, dig_o=6'h3F, led_o=0, buzz_o=0.
  - Reset mid-frame aborts the scan; the next frame starts at idx 0.
- Prescaler cnt:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap cycle (cnt==SCAN_DIV-1), idx advances 0,1,2,3,4,5,0.
- Frame snapshot:
  - On any cycle with cnt==0 and idx==0, snap <= disp_i. This includes the first cycle after reset.
  - disp_i changes mid-frame have no effect until the next frame start (no tearing).
- Output register, latency 1. Values at cycle t+1 come from state at cycle t:
  - If cnt<BLANK_CYC: dig_o=6'h3F (all off), seg_o=8'hFF.
  - Else: dig_o = ~(6'b1<<idx), seg_o = ~snap[8*idx +: 8].
  - Because BLANK_CYC>=1, a digit is never enabled on stale pre-snapshot data.
- Per slot: exactly SCAN_DIV-BLANK_CYC cycles with one digit enabled. A frame is 6*SCAN_DIV cycles.
- LEDs: led_o <= mode_i every cycle. No check on the one-hot property.
- Buzzer:
  - While alm_i=1: bcnt counts 0..BUZZ_DIV-1. On wrap, bph toggles. buzz_o <= bph.
  - First high phase starts BUZZ_DIV cycles after alm_i rises.
  - While alm_i=0: bcnt=0, bph=0, buzz_o <= 0. Deassertion forces buzz_o=0 on the next cycle, mid-phase included.
  - Re-assertion restarts from phase 0.
- Simultaneous events: rst overrides everything. Snapshot load and output register update in the same cycle is legal; the output uses the old snap, which is blanked anyway.
- Never more than one dig_o bit low in any cycle.

Optional Feature:
- Macro: SEG_SCAN_ALARM_FLASH_EN.
- Defined: while alm_i=1 and bph=0, dig_o is forced to 6'h3F and seg_o to 8'hFF. The display flashes in phase with the buzzer. Normal scanning resumes on the next cycle after alm_i falls.
- Undefined: alm_i affects only buzz_o. The display is unaffected.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, BUZZ_DIV=4):
- Reset: rst=1 for 3 cycles with arbitrary inputs -> seg_o=8'hFF, dig_o=6'h3F, led_o=0, buzz_o=0 throughout. Hold for one cycle after release.
- Scan: disp_i=48'h3F06_5B4F_6677, released from reset.
  - Slot 0, cnt 2..7: dig_o=6'h3E, seg_o=8'h88.
  - Slot 5: dig_o=6'h1F, seg_o=8'hC0.
  - Each slot: exactly 2 blank cycles, 6 enabled cycles. Frame length 48 cycles.
- No tearing: disp_i changed to 48'h0 during slot 2 -> slots 3..5 still show the old bytes. The next frame shows seg_o=8'hFF with the digit enabled.
- Buzzer: alm_i rises -> buzz_o goes 1 after 4 cycles, then toggles every 4 cycles. alm_i drops mid-high-phase -> buzz_o=0 the next cycle.
- Mode/reset mid-frame: mode_i=8'h08 -> led_o=8'h08 one cycle later. rst pulsed at idx=3, cnt=5 -> dig_o=6'h3F the next cycle, scan restarts at digit 0 with a fresh snapshot.
- Flash (macro defined): alm_i=1 -> dig_o=6'h3F during every bph=0 phase and normal scanning during bph=1. Macro undefined -> scan identical to the alm_i=0 case.
